// File: rtl/alu_seq16.sv
// alu_seq16: sequences one 16-bit request through an 8-bit 74181-style ALU
// in two passes (low byte, then high byte) with an active-low carry chain.
//
// Ports:
//   CLK, RST                 clock, async active-low reset
//   req, ready               request handshake (transfer on req && ready)
//   req_mode, req_sel        ALU mode (1 = logic) and selector for the request
//   req_a, req_b, req_cin_n  16-bit operands and active-low carry-in
//   req_byte                 8-bit-only request (only with ALU_SEQ_BYTE_EN)
//   done                     one-cycle pulse, result/flags valid
//   result, cout_n, zero_n   assembled F, active-low carry-out and zero flag
//   alu_a, alu_b, alu_mode,
//   alu_sel, alu_cin_n       drive bundle to the shared ALU
//   alu_f, alu_cout_n        combinational ALU response
//
// Optional feature: define ALU_SEQ_BYTE_EN to add the single-pass byte request.
module alu_seq16 (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req,
    input  logic        req_mode,
    input  logic [3:0]  req_sel,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic        req_cin_n,
`ifdef ALU_SEQ_BYTE_EN
    input  logic        req_byte,
`endif
    output logic        ready,
    output logic        done,
    output logic [15:0] result,
    output logic        cout_n,
    output logic        zero_n,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_mode,
    output logic [3:0]  alu_sel,
    output logic        alu_cin_n,
    input  logic [7:0]  alu_f,
    input  logic        alu_cout_n
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        mode_q;
    logic [3:0]  sel_q;
    logic        cin_n_q;
    logic        carry_n;
    logic [7:0]  lo_q;
`ifdef ALU_SEQ_BYTE_EN
    logic        byte_q;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            result  <= 16'h0000;
            cout_n  <= 1'b1;
            zero_n  <= 1'b1;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            mode_q  <= 1'b0;
            sel_q   <= 4'h0;
            cin_n_q <= 1'b1;
            carry_n <= 1'b1;
            lo_q    <= 8'h00;
`ifdef ALU_SEQ_BYTE_EN
            byte_q  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        a_q     <= req_a;
                        b_q     <= req_b;
                        mode_q  <= req_mode;
                        sel_q   <= req_sel;
                        cin_n_q <= req_cin_n;
`ifdef ALU_SEQ_BYTE_EN
                        byte_q  <= req_byte;
`endif
                        ready   <= 1'b0;
                        state   <= LO;
                    end
                end
                LO: begin
                    // Low byte is held privately so result only moves at completion.
                    lo_q    <= alu_f;
                    carry_n <= alu_cout_n;
                    state   <= HI;
`ifdef ALU_SEQ_BYTE_EN
                    if (byte_q) begin
                        result <= {8'h00, alu_f};
                        cout_n <= mode_q | alu_cout_n;
                        zero_n <= |alu_f;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
`endif
                end
                HI: begin
                    result <= {alu_f, lo_q};
                    // Logic functions produce no meaningful carry.
                    cout_n <= mode_q | alu_cout_n;
                    zero_n <= |{alu_f, lo_q};
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Drive bundle is a pure function of state and latched request;
    // parked outside the two ALU passes.
    always_comb begin
        alu_mode  = 1'b1;
        alu_sel   = 4'h0;
        alu_a     = 8'h00;
        alu_b     = 8'h00;
        alu_cin_n = 1'b1;
        unique case (state)
            LO: begin
                alu_mode  = mode_q;
                alu_sel   = sel_q;
                alu_a     = a_q[7:0];
                alu_b     = b_q[7:0];
                alu_cin_n = cin_n_q;
            end
            HI: begin
                alu_mode  = mode_q;
                alu_sel   = sel_q;
                alu_a     = a_q[15:8];
                alu_b     = b_q[15:8];
                alu_cin_n = carry_n;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_alu_seq16.sv
// tb_alu_seq16: self-checking bench for alu_seq16 with a behavioural
// 8-bit ALU attached and a whole-word reference model.
module tb_alu_seq16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req;
    logic        req_mode;
    logic [3:0]  req_sel;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        req_cin_n;
`ifdef ALU_SEQ_BYTE_EN
    logic        req_byte;
`endif
    logic        ready;
    logic        done;
    logic [15:0] result;
    logic        cout_n;
    logic        zero_n;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_mode;
    logic [3:0]  alu_sel;
    logic        alu_cin_n;
    logic [7:0]  alu_f;
    logic        alu_cout_n;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    alu_seq16 dut (
        .CLK        (CLK),
        .RST        (RST),
        .req        (req),
        .req_mode   (req_mode),
        .req_sel    (req_sel),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin_n  (req_cin_n),
`ifdef ALU_SEQ_BYTE_EN
        .req_byte   (req_byte),
`endif
        .ready      (ready),
        .done       (done),
        .result     (result),
        .cout_n     (cout_n),
        .zero_n     (zero_n),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_mode   (alu_mode),
        .alu_sel    (alu_sel),
        .alu_cin_n  (alu_cin_n),
        .alu_f      (alu_f),
        .alu_cout_n (alu_cout_n)
    );

    // Bitwise logic functions of the ALU, any width up to 16.
    function automatic logic [15:0] lfun(input logic [3:0] s,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
        case (s)
            4'h0: return ~a;
            4'h1: return ~(a & b);
            4'h2: return ~a | b;
            4'h3: return 16'hFFFF;
            4'h4: return ~(a | b);
            4'h5: return ~b;
            4'h6: return ~(a ^ b);
            4'h7: return a | ~b;
            4'h8: return ~a & b;
            4'h9: return a ^ b;
            4'hA: return b;
            4'hB: return a | b;
            4'hC: return 16'h0000;
            4'hD: return a & ~b;
            4'hE: return a & b;
            default: return a;
        endcase
    endfunction

    // Second arithmetic operand: 6 ADD, 9 SUB, C double, otherwise A plus carry.
    function automatic logic [15:0] op2(input logic [3:0] s,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
        case (s)
            4'h6: return b;
            4'h9: return ~b;
            4'hC: return a;
            default: return 16'h0000;
        endcase
    endfunction

    // 8-bit ALU: returns {cout_n, f}. Logic mode drives cout_n low on purpose.
    function automatic logic [8:0] alu8(input logic m, input logic [3:0] s,
                                        input logic [7:0] a, input logic [7:0] b,
                                        input logic ci_n);
        logic [15:0] lf;
        logic [15:0] o;
        logic [8:0]  sum;
        if (m) begin
            lf = lfun(s, {8'h00, a}, {8'h00, b});
            return {1'b0, lf[7:0]};
        end
        o = op2(s, {8'h00, a}, {8'h00, b});
        if (s == 4'h9) o[15:8] = 8'h00;
        sum = {1'b0, a} + {1'b0, o[7:0]} + {8'h00, ~ci_n};
        return {~sum[8], sum[7:0]};
    endfunction

    always_comb begin
        {alu_cout_n, alu_f} = alu8(alu_mode, alu_sel, alu_a, alu_b, alu_cin_n);
    end

    // Whole-word reference: returns {zero_n, cout_n, result}.
    function automatic logic [17:0] ref16(input logic m, input logic [3:0] s,
                                          input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic ci_n);
        logic [16:0] sum;
        logic [15:0] r;
        logic        co;
        if (m) begin
            r  = lfun(s, a, b);
            co = 1'b1;
        end else begin
            sum = {1'b0, a} + {1'b0, op2(s, a, b)} + {16'h0000, ~ci_n};
            r   = sum[15:0];
            co  = ~sum[16];
        end
        return {(r != 16'h0000), co, r};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_park(input string nm);
        chk(nm, {10'd0, alu_mode, alu_sel, alu_a, alu_b, alu_cin_n},
            {10'd0, 1'b1, 4'h0, 8'h00, 8'h00, 1'b1});
    endtask

    // One full request; lat = negedges from acceptance edge to done seen.
    task automatic run_op(input string nm, input logic m, input logic [3:0] s,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input int lat,
                          input logic [15:0] er, input logic eco,
                          input logic ez);
        int n;
        logic [15:0] prev;
        n = 0;
        while (!ready && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk({nm, "_ready_in"}, 32'(ready), 32'd1);
        prev = result;
        req       = 1'b1;
        req_mode  = m;
        req_sel   = s;
        req_a     = a;
        req_b     = b;
        req_cin_n = ci;
        @(negedge CLK);
        req       = 1'b0;
        req_a     = 16'($urandom);
        req_b     = 16'($urandom);
        req_sel   = 4'($urandom);
        req_mode  = 1'($urandom);
        req_cin_n = 1'($urandom);
        chk({nm, "_busy"}, 32'(ready), 32'd0);
        chk({nm, "_hold"}, 32'(result), 32'(prev));
        n = 1;
        while (!done && n < 8) begin
            @(negedge CLK);
            n++;
        end
        chk({nm, "_lat"}, 32'(n), 32'(lat));
        chk({nm, "_result"}, 32'(result), 32'(er));
        chk({nm, "_cout_n"}, 32'(cout_n), 32'(eco));
        chk({nm, "_zero_n"}, 32'(zero_n), 32'(ez));
        chk({nm, "_rdy_done"}, 32'(ready), 32'd0);
        chk_park({nm, "_park_done"});
        @(negedge CLK);
        chk({nm, "_pulse"}, {30'd0, done, ready}, {30'd0, 1'b0, 1'b1});
    endtask

    typedef struct {
        logic        m;
        logic [3:0]  s;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] r;
        logic        co;
        logic        z;
    } vec_t;

    vec_t tbl[8];
    logic [3:0] asel[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int first_done;
        int second_done;
        int seen;
        logic [17:0] e;
        logic        m;
        logic [3:0]  s;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;

        tbl[0] = '{1'b0, 4'h6, 16'h00F1, 16'h000F, 1'b1, 16'h0100, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 4'hF, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 4'h9, 16'h0001, 16'h0003, 1'b0, 16'hFFFE, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 4'h9, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 4'hE, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 4'h6, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 4'h6, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 4'h0, 16'h00FF, 16'h0000, 1'b1, 16'hFF00, 1'b1, 1'b1};
        asel[0] = 4'h6;
        asel[1] = 4'h9;
        asel[2] = 4'hC;
        asel[3] = 4'hF;

        RST       = 1'b0;
        req       = 1'b0;
        req_mode  = 1'b0;
        req_sel   = 4'h0;
        req_a     = 16'h0000;
        req_b     = 16'h0000;
        req_cin_n = 1'b1;
`ifdef ALU_SEQ_BYTE_EN
        req_byte  = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", {30'd0, cout_n, zero_n}, {30'd0, 1'b1, 1'b1});
        chk_park("rst_park");
        RST = 1'b1;
        @(negedge CLK);

        foreach (tbl[i]) begin
            run_op($sformatf("tbl%0d", i), tbl[i].m, tbl[i].s, tbl[i].a,
                   tbl[i].b, tbl[i].ci, 3, tbl[i].r, tbl[i].co, tbl[i].z);
        end

        // ADD carry chain: low-pass carry must reach alu_cin_n during HI.
        req = 1'b1; req_mode = 1'b0; req_sel = 4'h6;
        req_a = 16'h00F1; req_b = 16'h000F; req_cin_n = 1'b1;
        @(negedge CLK);
        req = 1'b0;
        chk("lo_bus", {10'd0, alu_mode, alu_sel, alu_a, alu_b, alu_cin_n},
            {10'd0, 1'b0, 4'h6, 8'hF1, 8'h0F, 1'b1});
        @(negedge CLK);
        chk("hi_bus", {10'd0, alu_mode, alu_sel, alu_a, alu_b, alu_cin_n},
            {10'd0, 1'b0, 4'h6, 8'h00, 8'h00, 1'b0});
        @(negedge CLK);
        chk("chain_done", 32'(done), 32'd1);
        chk("chain_result", 32'(result), 32'h0100);
        @(negedge CLK);

        // Reset during HI aborts with no done and no partial result.
        req = 1'b1; req_mode = 1'b0; req_sel = 4'h6;
        req_a = 16'h1234; req_b = 16'h1111; req_cin_n = 1'b1;
        @(negedge CLK);
        req = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_flags", {29'd0, cout_n, zero_n, done},
            {29'd0, 1'b1, 1'b1, 1'b0});
        chk("abort_ready", 32'(ready), 32'd1);
        chk_park("abort_park");
        @(negedge CLK);
        RST = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (done) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        chk("abort_ready_after", 32'(ready), 32'd1);

        // XOR, then a second request held from LO onward.
        req = 1'b1; req_mode = 1'b1; req_sel = 4'h9;
        req_a = 16'h1234; req_b = 16'h1234; req_cin_n = 1'b1;
        @(negedge CLK);
        req_mode = 1'b0; req_sel = 4'h6;
        req_a = 16'h0001; req_b = 16'h0001; req_cin_n = 1'b1;
        first_done = 0;
        second_done = 0;
        for (int k = 1; k <= 8; k++) begin
            if (done) begin
                if (first_done == 0) first_done = k;
                else second_done = k;
            end
            if (k < 4) chk($sformatf("b2b_busy%0d", k), 32'(ready), 32'd0);
            if (k >= 3 && k < 7)
                chk($sformatf("b2b_hold%0d", k), 32'(result), 32'd0);
            if (k == 3)
                chk("b2b_xor_flags", {30'd0, cout_n, zero_n},
                    {30'd0, 1'b1, 1'b0});
            if (k == 4) chk("b2b_ready", 32'(ready), 32'd1);
            if (k == 5) req = 1'b0;
            if (k == 7) chk("b2b_second", 32'(result), 32'h0002);
            @(negedge CLK);
        end
        chk("b2b_first_done", 32'(first_done), 32'd3);
        chk("b2b_second_done", 32'(second_done), 32'd7);

`ifdef ALU_SEQ_BYTE_EN
        req_byte = 1'b1;
        run_op("byte_add", 1'b0, 4'h6, 16'h00FF, 16'h0001, 1'b1, 2,
               16'h0000, 1'b0, 1'b0);
        req_byte = 1'b0;
`endif

        for (int i = 0; i < 150; i++) begin
            m  = 1'($urandom);
            s  = m ? 4'($urandom) : asel[$urandom_range(0, 3)];
            a  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            ci = 1'($urandom);
            e  = ref16(m, s, a, b, ci);
            run_op($sformatf("rnd%0d", i), m, s, a, b, ci, 3,
                   e[15:0], e[16], e[17]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
